// File: rtl/edge_stream_5x5_if.sv
// Pixel stream bundle for the 5x5 edge filter: input stream, output stream and frame mode.
// Latency: none (wires only).
// Backpressure: in_ready / out_ready carry valid-ready flow control in each direction.
interface edge_stream_5x5_if #(
   parameter int PIX_W = 8
);
   logic [1:0]       mode;
   logic             in_valid;
   logic             in_ready;
   logic             in_sof;
   logic [PIX_W-1:0] in_pixel;
   logic             out_valid;
   logic             out_ready;
   logic [PIX_W-1:0] out_pixel;
   logic             out_last;

   // Pixel source and sink side
   modport master (
      output mode, in_valid, in_sof, in_pixel, out_ready,
      input  in_ready, out_valid, out_pixel, out_last
   );

   // Filter side
   modport slave (
      input  mode, in_valid, in_sof, in_pixel, out_ready,
      output in_ready, out_valid, out_pixel, out_last
   );
endinterface

// File: rtl/edge_stream_5x5.sv
// Streaming 5x5 Sobel-type edge filter (Gy, Gx or |Gx|+|Gy|) over a raster pixel stream.
// Latency: out_valid rises 3 enabled cycles after the accept that completes a window.
// Backpressure: a single global enable (!out_valid || out_ready) stalls everything; in_ready = enable.
module edge_stream_5x5 #(
   parameter int PIX_W = 8,
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int SHIFT = 4
) (
   input  logic             clk,
   input  logic             rst,
   edge_stream_5x5_if.slave bus
);
   localparam int ACC_W = PIX_W + 7;
   localparam int MAG_W = ACC_W + 1;
   localparam int CW    = $clog2(IMG_W);
   localparam int RW    = $clog2(IMG_H);
   localparam logic [CW-1:0]    COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0]    ROW_LAST = RW'(IMG_H - 1);
   localparam logic [MAG_W-1:0] PIX_MAX  = MAG_W'((1 << PIX_W) - 1);

   logic en;
   logic acc;

   // Raster position of the pixel being accepted, and the next expected position
   logic [CW-1:0] col_q, col_d, pix_col;
   logic [RW-1:0] row_q, row_d, pix_row;
   logic [1:0]    mode_q, mode_d, mode_eff;
   logic          at_origin;

   // Each line-buffer word holds one column of the four previous lines: {row-4, row-3, row-2, row-1}
   logic [4*PIX_W-1:0] lb_q [IMG_W];
   logic [4*PIX_W-1:0] lb_rd, lb_d;

   // Stage 0: window, indexed [row][col]; row 0 is the oldest line, col 4 the newest column
   logic [4:0][4:0][PIX_W-1:0] win_q, win_d;
   logic       s0_vld_q, s0_vld_d;
   logic       s0_last_q, s0_last_d;
   logic [1:0] s0_mode_q, s0_mode_d;

   // Stage 1: separable partial sums (py per column for Gy, px per row for Gx)
   logic signed [ACC_W-1:0] wx [5][5];
   logic signed [ACC_W-1:0] py_q [5];
   logic signed [ACC_W-1:0] py_d [5];
   logic signed [ACC_W-1:0] px_q [5];
   logic signed [ACC_W-1:0] px_d [5];
   logic       s1_vld_q, s1_vld_d;
   logic       s1_last_q, s1_last_d;
   logic [1:0] s1_mode_q, s1_mode_d;

   // Stage 2: output register
   logic signed [ACC_W-1:0] gy, gx;
   logic [ACC_W-1:0]        ay, ax;
   logic [MAG_W-1:0]        mag, shifted;
   logic [PIX_W-1:0]        sat;
   logic                    out_valid_q, out_valid_d;
   logic                    out_last_q, out_last_d;
   logic [PIX_W-1:0]        out_pixel_q, out_pixel_d;

   assign en            = !out_valid_q || bus.out_ready;
   assign acc           = bus.in_valid && en;
   assign bus.in_ready  = en;
   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_pixel = out_pixel_q;

   // Position tracking: in_sof forces (0,0); mode is captured on every accept at (0,0)
   always_comb begin
      pix_col   = bus.in_sof ? '0 : col_q;
      pix_row   = bus.in_sof ? '0 : row_q;
      at_origin = (pix_col == '0) && (pix_row == '0);
      mode_eff  = at_origin ? bus.mode : mode_q;
      col_d     = col_q;
      row_d     = row_q;
      mode_d    = mode_q;
      if (acc) begin
         mode_d = mode_eff;
         if (pix_col == COL_LAST) begin
            col_d = '0;
            row_d = (pix_row == ROW_LAST) ? '0 : pix_row + 1'b1;
         end else begin
            col_d = pix_col + 1'b1;
            row_d = pix_row;
         end
      end
   end

   // Stage 0: shift the window left and insert the new column built from line buffers + pixel
   always_comb begin
      lb_rd     = lb_q[pix_col];
      lb_d      = {lb_rd[3*PIX_W-1:0], bus.in_pixel};
      win_d     = win_q;
      s0_vld_d  = 1'b0;
      s0_last_d = 1'b0;
      s0_mode_d = s0_mode_q;
      if (acc) begin
         for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) begin
               win_d[r][c] = win_q[r][c+1];
            end
         end
         win_d[0][4] = lb_rd[4*PIX_W-1 -: PIX_W];
         win_d[1][4] = lb_rd[3*PIX_W-1 -: PIX_W];
         win_d[2][4] = lb_rd[2*PIX_W-1 -: PIX_W];
         win_d[3][4] = lb_rd[PIX_W-1:0];
         win_d[4][4] = bus.in_pixel;
         // The window only spans real pixels of one frame once four lines and four columns precede it
         s0_vld_d  = (pix_row >= RW'(4)) && (pix_col >= CW'(4));
         s0_last_d = (pix_row == ROW_LAST) && (pix_col == COL_LAST);
         s0_mode_d = mode_eff;
      end
   end

   // Stage 1: the kernel is [-1 -2 0 2 1] x [1 4 6 4 1]; apply the derivative taps first
   always_comb begin
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 5; c++) begin
            wx[r][c] = ACC_W'(win_q[r][c]);
         end
      end
      for (int i = 0; i < 5; i++) begin
         py_d[i] = wx[4][i] + (wx[3][i] <<< 1) - (wx[1][i] <<< 1) - wx[0][i];
         px_d[i] = wx[i][4] + (wx[i][3] <<< 1) - (wx[i][1] <<< 1) - wx[i][0];
      end
      s1_vld_d  = s0_vld_q;
      s1_last_d = s0_last_q;
      s1_mode_d = s0_mode_q;
   end

   // Stage 2: smoothing taps, magnitude, mode select, scale and saturate
   always_comb begin
      gy = py_q[0] + (py_q[1] <<< 2) + (py_q[2] <<< 2) + (py_q[2] <<< 1) + (py_q[3] <<< 2) + py_q[4];
      gx = px_q[0] + (px_q[1] <<< 2) + (px_q[2] <<< 2) + (px_q[2] <<< 1) + (px_q[3] <<< 2) + px_q[4];
      ay = gy[ACC_W-1] ? -gy : gy;
      ax = gx[ACC_W-1] ? -gx : gx;
      case (s1_mode_q)
         2'd0:    mag = {1'b0, ay};
         2'd1:    mag = {1'b0, ax};
         default: mag = {1'b0, ay} + {1'b0, ax};
      endcase
      shifted     = mag >> SHIFT;
      sat         = (shifted > PIX_MAX) ? PIX_MAX[PIX_W-1:0] : shifted[PIX_W-1:0];
      out_pixel_d = s1_vld_q ? sat : out_pixel_q;
      out_valid_d = s1_vld_q;
      out_last_d  = s1_vld_q && s1_last_q;
   end

   // Line-buffer write; contents need no reset since rows 0-3 never produce output
   always_ff @(posedge clk) begin
      if (!rst && acc) begin
         lb_q[pix_col] <= lb_d;
      end
   end

   // Pipeline and counter registers, all advancing together on the global enable
   always_ff @(posedge clk) begin
      if (rst) begin
         col_q       <= '0;
         row_q       <= '0;
         mode_q      <= '0;
         win_q       <= '0;
         s0_vld_q    <= 1'b0;
         s0_last_q   <= 1'b0;
         s0_mode_q   <= '0;
         for (int i = 0; i < 5; i++) begin
            py_q[i] <= '0;
            px_q[i] <= '0;
         end
         s1_vld_q    <= 1'b0;
         s1_last_q   <= 1'b0;
         s1_mode_q   <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_pixel_q <= '0;
      end else if (en) begin
         col_q       <= col_d;
         row_q       <= row_d;
         mode_q      <= mode_d;
         win_q       <= win_d;
         s0_vld_q    <= s0_vld_d;
         s0_last_q   <= s0_last_d;
         s0_mode_q   <= s0_mode_d;
         for (int i = 0; i < 5; i++) begin
            py_q[i] <= py_d[i];
            px_q[i] <= px_d[i];
         end
         s1_vld_q    <= s1_vld_d;
         s1_last_q   <= s1_last_d;
         s1_mode_q   <= s1_mode_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_pixel_q <= out_pixel_d;
      end
   end
endmodule
